mips_alu: RTL and testbench
===========================

MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of A, B and Output; all values below assume 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands and opcode fields are sampled this cycle.
REQ-005 A  input  WIDTH  first operand (rs).
REQ-006 B  input  WIDTH  second operand (rt or sign-extended immediate).
REQ-007 FuncCode  input  6  R-type funct field.
REQ-008 ALU_op  input  2  main-control operation class.
REQ-009 ALU_Ctl  output  4  registered decoded operation code.
REQ-010 Output  output  WIDTH  registered result.
REQ-011 Zero_Flag  output  1  registered; 1 when the registered result is all zeros.
REQ-012 Overflow  output  1  registered signed overflow of add/sub.
REQ-013 out_valid  output  1  registered copy of in_valid; qualifies the other outputs.

Function
REQ-014 Decode: ALU_op 00 -> add (0010); ALU_op 01 -> subtract (0110), FuncCode ignored; ALU_op 10 or 11 -> decode FuncCode.
REQ-015 FuncCode map: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111; 100111 nor 1100; any other value 1111 (invalid).
REQ-016 Operations: add = A+B mod 2^WIDTH; sub = A-B mod 2^WIDTH; and/or bitwise; nor = ~(A|B); slt = 1 if signed(A) < signed(B), else 0, zero-extended to WIDTH.
REQ-017 ALU_Ctl 1111 yields Output 0, Zero_Flag 1, Overflow 0.
REQ-018 Overflow = operand signs equal (add) or differ (sub) and result sign differs from A; forced 0 for all other operations.
REQ-019 slt is computed from the signed comparison, not from the subtraction sign bit alone, so it is correct when A-B overflows.
REQ-020 Latency is exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on all outputs after edge N.
REQ-021 When in_valid=0 at an edge, out_valid goes to 0 and ALU_Ctl, Output, Zero_Flag and Overflow hold their previous values.
REQ-022 There is no backpressure; a new operation may be accepted every cycle.
REQ-023 Zero_Flag is derived from the same result that is registered into Output, never from a stale value.

Reset
REQ-024 reset=1 at a rising edge sets ALU_Ctl=0000, Output=0, Zero_Flag=0, Overflow=0 and out_valid=0, overriding in_valid.
REQ-025 An operation sampled in the same cycle as reset is discarded; the first valid output follows the first in_valid=1 edge after reset deasserts.

Structure
REQ-026 A shared package holds the ALU_Ctl encodings, the FuncCode constants, the ALU_op class constants and the invalid code 1111.
REQ-027 Decode logic is one combinational sub-module, alu_decode (inputs FuncCode and ALU_op, output the 4-bit control code).
REQ-028 The top level contains the combinational execute logic and the single output register stage.

Verification
REQ-029 A=0x13989207, B=0x13989208, ALU_op=10, FuncCode sequence 100000/100010/100100/100101/101010 -> Output 0x2731240F / 0xFFFFFFFF / 0x13989200 / 0x1398920F / 0x00000001, each one cycle after its input, with Zero_Flag=0 throughout.
REQ-030 Same operands, ALU_op=11, FuncCode=100111 -> ALU_Ctl=1100, Output=0xEC676DF0; ALU_op=00 -> 0010 and sum; ALU_op=01 with FuncCode=111111 -> 0110, Output=0xFFFFFFFF.
REQ-031 beq-style check: A=B=0x12345678, ALU_op=01 -> Output=0, Zero_Flag=1, Overflow=0.
REQ-032 Overflow/slt corner cases: A=0x7FFFFFFF, B=1, add -> Output 0x80000000, Overflow=1; A=0x80000000, B=1, slt -> Output 1, Overflow=0.
REQ-033 Invalid/hold/reset: ALU_op=10 with FuncCode=000000 -> ALU_Ctl=1111, Output=0, Zero_Flag=1. Dropping in_valid -> outputs hold, out_valid=0. Asserting reset mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU: control codes, funct fields and the
// main-control operation classes.
package mips_alu_pkg;

    // Decoded ALU control codes (the value presented on ALU_Ctl)
    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_INVALID = 4'b1111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Main-control operation classes; anything else means "use funct"
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU control decoder: maps ALU_op / FuncCode to a 4-bit code.
module alu_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0] FuncCode,
    input  logic [1:0] ALU_op,
    output logic [3:0] alu_ctl
);

    // Loads/stores force add, branches force subtract, R-type uses funct
    always_comb begin
        alu_ctl = CTL_INVALID;
        case (ALU_op)
            ALUOP_ADD: alu_ctl = CTL_ADD;
            ALUOP_SUB: alu_ctl = CTL_SUB;
            default: begin
                case (FuncCode)
                    FUNCT_ADD: alu_ctl = CTL_ADD;
                    FUNCT_SUB: alu_ctl = CTL_SUB;
                    FUNCT_AND: alu_ctl = CTL_AND;
                    FUNCT_OR:  alu_ctl = CTL_OR;
                    FUNCT_SLT: alu_ctl = CTL_SLT;
                    FUNCT_NOR: alu_ctl = CTL_NOR;
                    default:   alu_ctl = CTL_INVALID;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// MIPS ALU: decode + combinational execute followed by one output register
// stage. Outputs hold while in_valid is low.
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       FuncCode,
    input  logic [1:0]       ALU_op,
    output logic [3:0]       ALU_Ctl,
    output logic [WIDTH-1:0] Output,
    output logic             Zero_Flag,
    output logic             Overflow,
    output logic             out_valid
);

    logic [3:0]       dec_ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_lt_b;
    logic [WIDTH-1:0] result;
    logic             ovf;

    logic [3:0]       ctl_d,    ctl_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d,   zero_q;
    logic             ovf_d,    ovf_q;
    logic             valid_d,  valid_q;

    alu_decode u_decode (
        .FuncCode (FuncCode),
        .ALU_op   (ALU_op),
        .alu_ctl  (dec_ctl)
    );

    assign sum    = A + B;
    assign diff   = A - B;
    // True signed compare so slt stays correct when A-B overflows
    assign a_lt_b = ($signed(A) < $signed(B));

    // Execute the decoded operation and derive signed overflow for add/sub
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (dec_ctl)
            CTL_ADD: begin
                result = sum;
                ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            CTL_SUB: begin
                result = diff;
                ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            CTL_AND: result = A & B;
            CTL_OR:  result = A | B;
            CTL_NOR: result = ~(A | B);
            CTL_SLT: result = {{(WIDTH-1){1'b0}}, a_lt_b};
            default: result = '0;
        endcase
    end

    // Load a new result only on valid input; zero flag comes from that same result
    always_comb begin
        ctl_d    = ctl_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = in_valid;
        if (in_valid) begin
            ctl_d    = dec_ctl;
            result_d = result;
            zero_d   = (result == '0);
            ovf_d    = ovf;
        end
    end

    // Single output register stage with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q    <= 4'b0000;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            ctl_q    <= ctl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign ALU_Ctl   = ctl_q;
    assign Output    = result_q;
    assign Zero_Flag = zero_q;
    assign Overflow  = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: directed vectors with hand-derived results,
// then random traffic checked against an arithmetic reference model.
module tb_mips_alu;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  ctl;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] A, B;
    logic [5:0]  FuncCode;
    logic [1:0]  ALU_op;
    logic [3:0]  ALU_Ctl;
    logic [31:0] Output;
    logic        Zero_Flag, Overflow, out_valid;

    int total = 0;
    int bad   = 0;
    exp_t q[$];
    bit   mon_done = 0;

    mips_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .FuncCode  (FuncCode),
        .ALU_op    (ALU_op),
        .ALU_Ctl   (ALU_Ctl),
        .Output    (Output),
        .Zero_Flag (Zero_Flag),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operation chosen from the opcode tables, results from plain arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic [5:0] fn);
        exp_t   e;
        string  kind;
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0)      kind = "add";
        else if (op == 2'd1) kind = "sub";
        else begin
            case (fn)
                6'd32:   kind = "add";
                6'd34:   kind = "sub";
                6'd36:   kind = "and";
                6'd37:   kind = "or";
                6'd42:   kind = "slt";
                6'd39:   kind = "nor";
                default: kind = "bad";
            endcase
        end
        e.ovf = 1'b0;
        e.out = 32'd0;
        case (kind)
            "add": begin
                e.ctl = 4'd2;  wide = sa + sb; e.out = wide[31:0];
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            "sub": begin
                e.ctl = 4'd6;  wide = sa - sb; e.out = wide[31:0];
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            "and": begin e.ctl = 4'd0;  e.out = a & b; end
            "or":  begin e.ctl = 4'd1;  e.out = a | b; end
            "nor": begin e.ctl = 4'd12; e.out = ~(a | b); end
            "slt": begin e.ctl = 4'd7;  e.out = (sa < sb) ? 32'd1 : 32'd0; end
            default: e.ctl = 4'd15;
        endcase
        e.zero = (e.out == 32'd0);
        return e;
    endfunction

    // Apply one cycle of stimulus; accepted operations go to the scoreboard
    task automatic drive(input logic v, input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [5:0] fn, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; in_valid = v; A = a; B = b; ALU_op = op; FuncCode = fn;
        if (v && !rst) q.push_back(e);
    endtask

    // Monitor: sample control at the edge, compare outputs on the falling edge
    initial begin : monitor
        logic s_rst, s_v;
        exp_t held, got;
        int   n;
        held = '{ctl: 4'd0, out: 32'd0, zero: 1'b0, ovf: 1'b0};
        n = 0;
        while (!mon_done) begin
            @(posedge clk);
            s_rst = reset;
            s_v   = in_valid;
            @(negedge clk);
            if (s_rst) begin
                held = '{ctl: 4'd0, out: 32'd0, zero: 1'b0, ovf: 1'b0};
                check("rst_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                check("out_valid", {31'd0, out_valid}, {31'd0, s_v});
                if (s_v) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL underflow: got output with empty scoreboard expected none");
                    end else begin
                        got = q.pop_front();
                        held = got;
                        n++;
                        $display("txn %0d ctl=%b out=%08h zero=%b ovf=%b", n, ALU_Ctl, Output, Zero_Flag, Overflow);
                    end
                end
            end
            check("ALU_Ctl",   {28'd0, ALU_Ctl},   {28'd0, held.ctl});
            check("Output",    Output,             held.out);
            check("Zero_Flag", {31'd0, Zero_Flag}, {31'd0, held.zero});
            check("Overflow",  {31'd0, Overflow},  {31'd0, held.ovf});
        end
    end

    vec_t dir[$];
    logic [31:0] corner [6];

    initial begin : stim
        exp_t e0, e;
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [5:0]  fnl [6];
        logic        v, r;
        fnl[0] = 6'b100000; fnl[1] = 6'b100010; fnl[2] = 6'b100100;
        fnl[3] = 6'b100101; fnl[4] = 6'b101010; fnl[5] = 6'b100111;
        corner[0] = 32'h0000_0000; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h1398_9207;
        e0 = '{ctl: 4'd0, out: 32'd0, zero: 1'b0, ovf: 1'b0};

        reset = 1'b1; in_valid = 1'b1; A = 32'h1; B = 32'h1; ALU_op = 2'b00; FuncCode = 6'd0;
        // Reset held with in_valid high: those operations are discarded
        drive(1, 1, 32'h5, 32'h6, 2'b00, 6'd0, e0);
        drive(1, 1, 32'h5, 32'h6, 2'b00, 6'd0, e0);

        // Directed vectors with hand-computed expectations
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b100000, 4'b0010, 32'h2731240F, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b100010, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b100100, 4'b0000, 32'h13989200, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b100101, 4'b0001, 32'h1398920F, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b101010, 4'b0111, 32'h00000001, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b11, 6'b100111, 4'b1100, 32'hEC676DF0, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b00, 6'b000000, 4'b0010, 32'h2731240F, 1'b0, 1'b0});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b01, 6'b111111, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0});
        dir.push_back('{32'h12345678, 32'h12345678, 2'b01, 6'b000000, 4'b0110, 32'h00000000, 1'b1, 1'b0});
        dir.push_back('{32'h7FFFFFFF, 32'h00000001, 2'b00, 6'b000000, 4'b0010, 32'h80000000, 1'b0, 1'b1});
        dir.push_back('{32'h80000000, 32'h00000001, 2'b10, 6'b101010, 4'b0111, 32'h00000001, 1'b0, 1'b0});
        dir.push_back('{32'h80000000, 32'h00000001, 2'b01, 6'b000000, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1});
        dir.push_back('{32'h13989207, 32'h13989208, 2'b10, 6'b000000, 4'b1111, 32'h00000000, 1'b1, 1'b0});
        foreach (dir[i]) begin
            e = '{ctl: dir[i].ctl, out: dir[i].out, zero: dir[i].zero, ovf: dir[i].ovf};
            drive(1, 0, dir[i].a, dir[i].b, dir[i].op, dir[i].fn, e);
        end
        // Valid result followed by idle cycles: outputs must hold
        e = '{ctl: 4'b0010, out: 32'h00000003, zero: 1'b0, ovf: 1'b0};
        drive(1, 0, 32'h1, 32'h2, 2'b00, 6'd0, e);
        repeat (3) drive(0, 0, 32'hDEADBEEF, 32'h0, 2'b10, 6'b100111, e0);
        // Reset in the middle of a valid stream
        e = '{ctl: 4'b0111, out: 32'h00000001, zero: 1'b0, ovf: 1'b0};
        drive(1, 0, 32'hFFFFFFFF, 32'h1, 2'b10, 6'b101010, e);
        drive(1, 1, 32'hFFFFFFFF, 32'h1, 2'b10, 6'b101010, e0);
        drive(0, 0, 32'h0, 32'h0, 2'b00, 6'd0, e0);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            a  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            b  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            if ($urandom_range(0, 9) == 0) b = a;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : fnl[$urandom_range(0, 5)];
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 49) == 0);
            drive(v, r, a, b, op, fn, model(a, b, op, fn));
        end
        repeat (3) drive(0, 0, 32'h0, 32'h0, 2'b00, 6'd0, e0);
        mon_done = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
